serial_uart_bridge: RTL

Bridges the processor's byte-wide serial port to a physical 8N1 UART line. Processor writes (data plus write-enable) are buffered in a TX FIFO and serialized on `uart_tx_out`. Frames arriving on `uart_rx_in` are deserialized into an RX FIFO and presented to the processor as a show-ahead byte with a valid flag, consumed by a read-enable pulse. The block sits at top level between the processor's serial ports and the board pins.

---
 rtl/serial_bridge_pkg.sv | 15 +
 rtl/byte_fifo.sv | 56 +++++
 rtl/serial_uart_bridge.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/serial_bridge_pkg.sv
// Shared definitions for the serial UART bridge: FSM state encoding
// (common to the TX and RX engines) and UART line constants.
package serial_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide show-ahead FIFO with full/empty/count status. Used once per
// direction of the bridge.
module byte_fifo
  import serial_bridge_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [UART_DATA_BITS-1:0] din_i,
  output logic [UART_DATA_BITS-1:0] dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]             rd_q, wr_q;
  logic [AW:0]               cnt_q, cnt_d;
  logic                      do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_FULL);
  assign count_o = cnt_q;
  // A push into a full FIFO fits only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// Processor serial port <-> 8N1 UART bridge: TX FIFO + serializer, 2-flop
// RX synchronizer + deserializer + RX FIFO, sticky error flags.
module serial_uart_bridge
  import serial_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cpu_wdata_in,
  input  logic       cpu_wren_in,
  output logic       cpu_ready_out,
  output logic [7:0] cpu_rdata_out,
  output logic       cpu_valid_out,
  input  logic       cpu_rden_in,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic       tx_overflow_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            FW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    DBIT_LAST = 3'(UART_DATA_BITS - 1);

  logic [7:0]    tx_head, rx_head;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [FW-1:0] tx_count, rx_count;
  logic          tx_pop, rx_push, unused_cnt;

  uart_state_e   tx_st_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_sh_q;
  logic          tx_line_q, tx_ovf_q, tx_bit_done;

  logic          rx_s1_q, rx_s2_q;
  uart_state_e   rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_ovr_q, rx_ferr_q, rx_stop_smp;

  assign tx_bit_done = (tx_cnt_q == BIT_LAST);
  assign tx_pop      = !tx_empty &&
                       ((tx_st_q == ST_IDLE) || (tx_st_q == ST_STOP && tx_bit_done));
  assign rx_stop_smp = (rx_st_q == ST_STOP) && (rx_cnt_q == BIT_LAST);
  assign rx_push     = rx_stop_smp && rx_s2_q;

  assign cpu_ready_out    = !tx_full;
  assign cpu_valid_out    = !rx_empty;
  assign cpu_rdata_out    = rx_head;
  assign uart_tx_out      = tx_line_q;
  assign tx_overflow_out  = tx_ovf_q;
  assign rx_overrun_out   = rx_ovr_q;
  assign rx_frame_err_out = rx_ferr_q;
  assign unused_cnt       = ^{tx_count, rx_count};

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (cpu_wren_in),
    .pop_i   (tx_pop),
    .din_i   (cpu_wdata_in),
    .dout_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (rx_push),
    .pop_i   (cpu_rden_in),
    .din_i   (rx_sh_q),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_st_q   <= ST_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_line_q <= UART_IDLE_LEVEL;
      tx_ovf_q  <= 1'b0;
    end else begin
      // The line lags the FSM by one cycle: a write shows up as a start bit two edges later.
      unique case (tx_st_q)
        ST_START: tx_line_q <= 1'b0;
        ST_DATA:  tx_line_q <= tx_sh_q[0];
        default:  tx_line_q <= UART_IDLE_LEVEL;
      endcase
      unique case (tx_st_q)
        ST_IDLE: if (tx_pop) begin
          tx_sh_q  <= tx_head;
          tx_cnt_q <= '0;
          tx_st_q  <= ST_START;
        end
        ST_START: if (tx_bit_done) begin
          tx_cnt_q <= '0;
          tx_bit_q <= '0;
          tx_st_q  <= ST_DATA;
        end else tx_cnt_q <= tx_cnt_q + CW'(1);
        ST_DATA: if (tx_bit_done) begin
          tx_cnt_q <= '0;
          tx_sh_q  <= tx_sh_q >> 1;
          tx_bit_q <= tx_bit_q + 3'd1;
          if (tx_bit_q == DBIT_LAST) tx_st_q <= ST_STOP;
        end else tx_cnt_q <= tx_cnt_q + CW'(1);
        ST_STOP: if (tx_bit_done) begin
          tx_cnt_q <= '0;
          if (tx_pop) begin
            tx_sh_q <= tx_head;
            tx_st_q <= ST_START;
          end else tx_st_q <= ST_IDLE;
        end else tx_cnt_q <= tx_cnt_q + CW'(1);
        default: tx_st_q <= ST_IDLE;
      endcase
      if (cpu_wren_in && tx_full && !tx_pop) tx_ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_s1_q   <= UART_IDLE_LEVEL;
      rx_s2_q   <= UART_IDLE_LEVEL;
      rx_st_q   <= ST_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_ovr_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_s1_q <= uart_rx_in;
      rx_s2_q <= rx_s1_q;
      unique case (rx_st_q)
        ST_IDLE: if (!rx_s2_q) begin
          rx_cnt_q <= '0;
          rx_st_q  <= ST_START;
        end
        // Mid-start resample; a line already back high was only a glitch.
        ST_START: if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx_s2_q ? ST_IDLE : ST_DATA;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        ST_DATA: if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_q <= '0;
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 3'd1;
          if (rx_bit_q == DBIT_LAST) rx_st_q <= ST_STOP;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        ST_STOP: if (rx_stop_smp) begin
          rx_cnt_q <= '0;
          rx_st_q  <= ST_IDLE;
          if (!rx_s2_q)                     rx_ferr_q <= 1'b1;
          else if (rx_full && !cpu_rden_in) rx_ovr_q  <= 1'b1;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        default: rx_st_q <= ST_IDLE;
      endcase
    end
  end

endmodule
